// File: rtl/monitor_comparacao_if.sv
`default_nettype none
// ============================================================================
// Module   : monitor_comparacao_if
// Brief    : Comparator-flag sample bus and filtered-status outputs.
// Revision : 1.0
// ============================================================================
interface monitor_comparacao_if #(
    parameter int LARGURA_CONT = 8
);
    logic                    amostra;
    logic                    igual;
    logic                    maior;
    logic                    menor;
    logic                    limpa;
    logic [1:0]              estado;
    logic                    alarme;
    logic [LARGURA_CONT-1:0] contagem;
    logic                    erro;

    // Upstream side: supplies the flags, observes the filtered status.
    modport master (
        output amostra, igual, maior, menor, limpa,
        input  estado, alarme, contagem, erro
    );

    modport slave (
        input  amostra, igual, maior, menor, limpa,
        output estado, alarme, contagem, erro
    );
endinterface
`default_nettype wire

// File: rtl/monitor_comparacao.sv
`default_nettype none
// ============================================================================
// Module   : monitor_comparacao
// Brief    : Debounced NEUTRO/BAIXO/ALTO classifier with ALTO-entry alarm/count.
// Revision : 1.0
// ============================================================================
module monitor_comparacao #(
    parameter int N_CONFIRMA   = 4,
    parameter int LARGURA_CONT = 8
) (
    input  wire                  clock,
    input  wire                  reset,
    monitor_comparacao_if.slave  bus
);
    typedef enum logic [1:0] {
        NEUTRO = 2'b00,
        BAIXO  = 2'b01,
        ALTO   = 2'b10
    } estado_t;

    localparam logic [3:0]              c_n_confirma = 4'(N_CONFIRMA);
    localparam logic [LARGURA_CONT-1:0] c_max_cont   = '1;

    estado_t                 r_estado;
    estado_t                 r_candidato;
    logic [3:0]              r_corrida;
    logic                    r_alarme;
    logic [LARGURA_CONT-1:0] r_contagem;
    logic                    r_erro;

    logic    w_valido;
    estado_t w_cand;
    logic [3:0] w_nova;

    always_comb begin
        w_valido = 1'b0;
        w_cand   = NEUTRO;
        case ({bus.igual, bus.maior, bus.menor})
            3'b100:  begin w_valido = 1'b1; w_cand = NEUTRO; end
            3'b010:  begin w_valido = 1'b1; w_cand = ALTO;   end
            3'b001:  begin w_valido = 1'b1; w_cand = BAIXO;  end
            default: begin w_valido = 1'b0; w_cand = NEUTRO; end
        endcase
    end

    // A run only continues when the same candidate was already being counted.
    assign w_nova = (w_cand == r_candidato && r_corrida != 4'd0) ?
                    r_corrida + 4'd1 : 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= NEUTRO;
            r_candidato <= NEUTRO;
            r_corrida   <= 4'd0;
            r_alarme    <= 1'b0;
            r_contagem  <= '0;
            r_erro      <= 1'b0;
        end else begin
            r_alarme <= 1'b0;
            if (bus.limpa) begin
                r_contagem <= '0;
                r_erro     <= 1'b0;
                r_corrida  <= 4'd0;
            end else if (bus.amostra) begin
                if (!w_valido) begin
                    r_erro    <= 1'b1;
                    r_corrida <= 4'd0;
                end else if (w_cand == r_estado) begin
                    r_corrida <= 4'd0;
                end else begin
                    r_candidato <= w_cand;
                    if (w_nova == c_n_confirma) begin
                        r_estado  <= w_cand;
                        r_corrida <= 4'd0;
                        if (w_cand == ALTO) begin
                            r_alarme <= 1'b1;
                            if (r_contagem != c_max_cont)
                                r_contagem <= r_contagem + 1'b1;
                        end
                    end else begin
                        r_corrida <= w_nova;
                    end
                end
            end
        end
    end

    assign bus.estado   = r_estado;
    assign bus.alarme   = r_alarme;
    assign bus.contagem = r_contagem;
    assign bus.erro     = r_erro;
endmodule
`default_nettype wire

// File: tb/tb_monitor_comparacao.sv
`default_nettype none
// ============================================================================
// Module   : tb_monitor_comparacao
// Brief    : Directed self-checking bench for monitor_comparacao.
// Revision : 1.0
// ============================================================================
module tb_monitor_comparacao;
    localparam int N_CONFIRMA   = 4;
    localparam int LARGURA_CONT = 2;

    localparam logic [2:0] F_IGUAL = 3'b100;
    localparam logic [2:0] F_MAIOR = 3'b010;
    localparam logic [2:0] F_MENOR = 3'b001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_alarme = 0;

    monitor_comparacao_if #(.LARGURA_CONT(LARGURA_CONT)) bus();

    monitor_comparacao #(
        .N_CONFIRMA   (N_CONFIRMA),
        .LARGURA_CONT (LARGURA_CONT)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (bus.alarme === 1'b1) n_alarme <= n_alarme + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle with the given inputs; returns #1 after the edge.
    task automatic drive(input logic r, input logic a, input logic [2:0] f, input logic l);
        @(negedge clock);
        reset       = r;
        bus.amostra = a;
        {bus.igual, bus.maior, bus.menor} = f;
        bus.limpa   = l;
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [2:0] f, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, f, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    int a0;

    initial begin
        bus.amostra = 1'b0; bus.igual = 1'b0; bus.maior = 1'b0;
        bus.menor = 1'b0; bus.limpa = 1'b0;

        // Reset values
        drive(1'b1, 1'b0, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 3'b000, 1'b0);
        idle(3);
        chk("rst_estado",   32'(bus.estado),   32'd0);
        chk("rst_alarme",   32'(bus.alarme),   32'd0);
        chk("rst_contagem", 32'(bus.contagem), 32'd0);
        chk("rst_erro",     32'(bus.erro),     32'd0);

        // Confirmation into ALTO
        strobe(F_MAIOR, 3);
        chk("conf_3_estado", 32'(bus.estado), 32'd0);
        chk("conf_3_alarme", 32'(bus.alarme), 32'd0);
        strobe(F_MAIOR, 1);
        chk("conf_4_estado",   32'(bus.estado),   32'd2);
        chk("conf_4_alarme",   32'(bus.alarme),   32'd1);
        chk("conf_4_contagem", 32'(bus.contagem), 32'd1);
        idle(1);
        chk("conf_pulse_end", 32'(bus.alarme), 32'd0);
        chk("conf_hold",      32'(bus.estado), 32'd2);

        // Back to NEUTRO with strobe gaps inside the run
        strobe(F_IGUAL, 1); idle(2); strobe(F_IGUAL, 2);
        chk("gap_3_estado", 32'(bus.estado), 32'd2);
        strobe(F_IGUAL, 1);
        chk("gap_4_estado", 32'(bus.estado), 32'd0);
        chk("gap_no_alarme", 32'(bus.alarme), 32'd0);

        // Interrupted run
        strobe(F_MAIOR, 2); strobe(F_MENOR, 1);
        chk("intr_menor_estado", 32'(bus.estado), 32'd0);
        strobe(F_MAIOR, 3);
        chk("intr_3_estado", 32'(bus.estado), 32'd0);
        strobe(F_MAIOR, 1);
        chk("intr_4_estado",   32'(bus.estado),   32'd2);
        chk("intr_4_alarme",   32'(bus.alarme),   32'd1);
        chk("intr_4_contagem", 32'(bus.contagem), 32'd2);

        // Invalid flags set sticky error, state holds
        strobe(3'b011, 1);
        chk("inv011_erro",   32'(bus.erro),   32'd1);
        chk("inv011_estado", 32'(bus.estado), 32'd2);
        strobe(3'b000, 1);
        chk("inv000_erro",   32'(bus.erro),   32'd1);
        chk("inv000_estado", 32'(bus.estado), 32'd2);
        strobe(F_IGUAL, 4);
        chk("inv_neutro", 32'(bus.estado), 32'd0);

        // limpa with simultaneous strobe: strobe discarded
        drive(1'b0, 1'b1, F_MAIOR, 1'b1);
        chk("limpa_erro",     32'(bus.erro),     32'd0);
        chk("limpa_contagem", 32'(bus.contagem), 32'd0);
        chk("limpa_estado",   32'(bus.estado),   32'd0);
        strobe(F_MAIOR, 3);
        chk("limpa_3_estado", 32'(bus.estado), 32'd0);
        strobe(F_MAIOR, 1);
        chk("limpa_4_estado",   32'(bus.estado),   32'd2);
        chk("limpa_4_contagem", 32'(bus.contagem), 32'd1);

        // Saturation of the 2-bit counter
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        chk("sat_clear", 32'(bus.contagem), 32'd0);
        a0 = n_alarme;
        for (int k = 1; k <= 5; k++) begin
            strobe(F_IGUAL, 4);
            strobe(F_MAIOR, 4);
            chk($sformatf("sat_contagem_%0d", k), 32'(bus.contagem), (k < 3) ? 32'(k) : 32'd3);
            chk($sformatf("sat_alarme_%0d", k),   32'(bus.alarme),   32'd1);
        end
        idle(1);
        chk("sat_pulses", 32'(n_alarme - a0), 32'd5);

        // Reset mid-run discards the pending run
        strobe(F_IGUAL, 4);
        a0 = n_alarme;
        strobe(F_MAIOR, 3);
        drive(1'b1, 1'b0, 3'b000, 1'b0);
        strobe(F_MAIOR, 1);
        chk("rstmid_estado", 32'(bus.estado), 32'd0);
        strobe(F_MAIOR, 2);
        chk("rstmid_3_estado", 32'(bus.estado), 32'd0);
        idle(2);
        chk("rstmid_no_alarme", 32'(n_alarme - a0), 32'd0);
        chk("rstmid_contagem",  32'(bus.contagem), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
